// File: rtl/layer_pkg.sv
// Shared layer definitions: pixel width, pooling mode codes and a
// constant-evaluable ceil(log2) helper used to size counters and accumulators.
// No ports; imported by pool_stage and pool_row_buffer.
package layer_pkg;

    localparam int PXL_DW   = 9;
    localparam int POOL_MAX = 0;
    localparam int POOL_AVG = 1;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// NP-entry accumulator array holding one partial pooling window per pooled column.
// Ports: clk/reset, combinational read port (rd_addr -> rd_data), one write port
// (wr_en, wr_addr) writing ld_data when ld is set, otherwise upd_data.
module pool_row_buffer
    import layer_pkg::*;
#(
    parameter int NP     = 14,
    parameter int AW     = PXL_DW,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [AW-1:0]     rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     ld,
    input  logic signed [AW-1:0]     ld_data,
    input  logic signed [AW-1:0]     upd_data
);

    logic signed [AW-1:0] acc [NP];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NP; i++) acc[i] <= '0;
        end else if (wr_en) begin
            acc[wr_addr] <= ld ? ld_data : upd_data;
        end
    end

    assign rd_data = acc[rd_addr];

endmodule

// File: rtl/pool_stage.sv
// Streaming KxK max/average pooling stage with optional ReLU and frame-last flag.
// Ports: clk/reset; pixel input stream (pxl_in, pxl_valid, pxl_ready); pooled output
// stream (pool_out, pool_valid, pool_ready, pool_last). One pixel per cycle, result
// registered on the edge accepting the window's last pixel; input stalls while output is held.
module pool_stage
    import layer_pkg::*;
#(
    parameter int DW    = PXL_DW,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 2,
    parameter int MODE  = POOL_MAX,
    parameter int RELU  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] pxl_in,
    input  logic                 pxl_valid,
    output logic                 pxl_ready,
    output logic signed [DW-1:0] pool_out,
    output logic                 pool_valid,
    input  logic                 pool_ready,
    output logic                 pool_last
);

    localparam int LK     = clog2(K);
    localparam int NP     = IMG_W / K;
    localparam int NH     = IMG_H / K;
    localparam int AW     = (MODE == POOL_AVG) ? DW + 2 * LK : DW;
    // Average divides by K*K, a power of two, so a floor shift is exact.
    localparam int SH     = (MODE == POOL_AVG) ? 2 * LK : 0;
    localparam int ADDR_W = (NP > 1) ? clog2(NP) : 1;
    localparam int CW_C   = clog2(IMG_W + 1);
    localparam int CW_R   = clog2(IMG_H + 1);

    logic [CW_C-1:0]      col;
    logic [CW_R-1:0]      row;
    logic                 accept;
    logic                 in_win;
    logic                 win_first;
    logic                 win_last;
    logic                 frame_last;
    logic [ADDR_W-1:0]    acc_addr;
    logic signed [AW-1:0] acc_rd;
    logic signed [AW-1:0] pxl_ext;
    logic signed [AW-1:0] comb;
    logic signed [DW-1:0] pool_res;
    logic signed [DW-1:0] relu_res;

    assign pxl_ready = !reset && (!pool_valid || pool_ready);
    assign accept    = pxl_valid && pxl_ready;

    // Trailing columns/rows that cannot complete a window are swallowed here.
    assign in_win     = (int'(col) < NP * K) && (int'(row) < NH * K);
    assign win_first  = (col[LK-1:0] == '0) && (row[LK-1:0] == '0);
    assign win_last   = (col[LK-1:0] == {LK{1'b1}}) && (row[LK-1:0] == {LK{1'b1}});
    assign frame_last = (int'(col) == NP * K - 1) && (int'(row) == NH * K - 1);
    assign acc_addr   = ADDR_W'(col >> LK);
    assign pxl_ext    = AW'(pxl_in);

    always_comb begin
        comb = acc_rd + pxl_ext;
        if (MODE == POOL_MAX) comb = (pxl_ext > acc_rd) ? pxl_ext : acc_rd;
    end

    assign pool_res = DW'(comb >>> SH);
    assign relu_res = ((RELU != 0) && pool_res[DW-1]) ? '0 : pool_res;

    pool_row_buffer #(
        .NP     (NP),
        .AW     (AW),
        .ADDR_W (ADDR_W)
    ) u_row_buffer (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (acc_addr),
        .rd_data  (acc_rd),
        .wr_en    (accept && in_win),
        .wr_addr  (acc_addr),
        .ld       (win_first),
        .ld_data  (pxl_ext),
        .upd_data (comb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW_C'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == CW_R'(IMG_H - 1)) ? '0 : row + CW_R'(1);
            end else begin
                col <= col + CW_C'(1);
            end
        end
    end

    // A new result can only arrive when pxl_ready was high, so a held result
    // is never overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pool_valid <= 1'b0;
            pool_out   <= '0;
            pool_last  <= 1'b0;
        end else if (accept && in_win && win_last) begin
            pool_valid <= 1'b1;
            pool_out   <= relu_res;
            pool_last  <= frame_last;
        end else if (pool_ready) begin
            pool_valid <= 1'b0;
        end
    end

endmodule
